// File: rtl/clk_div_speed_ctrl_pkg.sv
// clk_div_speed_ctrl_pkg: shared speed indices, controller state encoding and speed stepping helper
package clk_div_speed_ctrl_pkg;
  localparam int SPEED_W = 2;
  typedef logic [SPEED_W-1:0] speed_t;
  localparam speed_t SPD_1HZ  = 2'd0;
  localparam speed_t SPD_5HZ  = 2'd1;
  localparam speed_t SPD_10HZ = 2'd2;
  localparam speed_t SPD_50HZ = 2'd3;
  typedef enum logic {RUN, PEND} state_t;
  function automatic speed_t next_speed(input speed_t s);
    return speed_t'(s + 1'b1);
  endfunction
endpackage

// File: rtl/clk_div_speed_ctrl_if.sv
// clk_div_speed_ctrl_if: speed request handshake plus divided clock outputs
// master drives speed_req/req_valid/auto_en; slave returns req_ready/ClkOut/tick/cur_speed/busy
interface clk_div_speed_ctrl_if;
  import clk_div_speed_ctrl_pkg::*;
  speed_t speed_req;
  speed_t cur_speed;
  logic req_valid;
  logic req_ready;
  logic auto_en;
  logic ClkOut;
  logic tick;
  logic busy;
  modport master(output speed_req, req_valid, auto_en, input req_ready, ClkOut, tick, cur_speed, busy);
  modport slave(input speed_req, req_valid, auto_en, output req_ready, ClkOut, tick, cur_speed, busy);
endinterface

// File: rtl/clk_div_core.sv
// clk_div_core: divide counter with 50% duty toggle and rise tick
// in: Clk50MHz, Rst, half (half-period), load (force counter restart); out: bnd (half-period boundary), ClkOut, tick
module clk_div_core #(
  parameter int CNT_W = 25
) (
  input  logic             Clk50MHz,
  input  logic             Rst,
  input  logic [CNT_W-1:0] half,
  input  logic             load,
  output logic             bnd,
  output logic             ClkOut,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  assign bnd = cnt == half;
  always_ff @(posedge Clk50MHz)
    if (Rst) begin
      cnt    <= CNT_W'(1);
      ClkOut <= 1'b0;
      tick   <= 1'b0;
    end else begin
      cnt    <= bnd || load ? CNT_W'(1) : cnt + 1'b1;
      ClkOut <= ClkOut ^ bnd;
      tick   <= bnd && !ClkOut;
    end
endmodule

// File: rtl/clk_div_speed_ctrl.sv
// clk_div_speed_ctrl: runtime speed controller applying speed changes only at half-period boundaries
// in: Clk50MHz, Rst; ctl (slave): speed_req/req_valid/auto_en in, req_ready/ClkOut/tick/cur_speed/busy out
// SPEED_AUTO_SEQ_EN adds an auto-sequencer stepping to the next speed every DWELL ClkOut rises
module clk_div_speed_ctrl import clk_div_speed_ctrl_pkg::*; #(
  parameter int CNT_W  = 25,
  parameter int HALF_0 = 25_000_000,
  parameter int HALF_1 = 5_000_000,
  parameter int HALF_2 = 2_500_000,
  parameter int HALF_3 = 500_000,
  parameter int DWELL  = 4
) (
  input logic                 Clk50MHz,
  input logic                 Rst,
  clk_div_speed_ctrl_if.slave ctl
);
  state_t state;
  speed_t pend;
  logic bnd;
  logic auto_req;
  logic [CNT_W-1:0] half;
  assign half = ctl.cur_speed == SPD_1HZ ? CNT_W'(HALF_0) :
                ctl.cur_speed == SPD_5HZ ? CNT_W'(HALF_1) :
                ctl.cur_speed == SPD_10HZ ? CNT_W'(HALF_2) : CNT_W'(HALF_3);
  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .Clk50MHz(Clk50MHz),
    .Rst(Rst),
    .half(half),
    .load(state == PEND && bnd),
    .bnd(bnd),
    .ClkOut(ctl.ClkOut),
    .tick(ctl.tick)
  );
`ifdef SPEED_AUTO_SEQ_EN
  localparam int DW = $clog2(DWELL + 1);
  logic [DW-1:0] dwell;
  assign auto_req = ctl.auto_en && ctl.tick && dwell == DW'(DWELL - 1);
  // ticks are only counted while idle; any accepted request restarts the dwell
  always_ff @(posedge Clk50MHz)
    if (Rst || !ctl.auto_en || (state == RUN && (ctl.req_valid || auto_req))) dwell <= '0;
    else if (state == RUN && ctl.tick) dwell <= dwell + 1'b1;
`else
  logic unused_auto;
  assign auto_req = 1'b0;
  assign unused_auto = ctl.auto_en;
`endif
  always_ff @(posedge Clk50MHz)
    if (Rst) begin
      state         <= RUN;
      pend          <= SPD_1HZ;
      ctl.cur_speed <= SPD_1HZ;
      ctl.req_ready <= 1'b1;
      ctl.busy      <= 1'b0;
    end else if (state == RUN) begin
      if (ctl.req_valid || auto_req) begin
        state         <= PEND;
        pend          <= ctl.req_valid ? ctl.speed_req : next_speed(ctl.cur_speed);
        ctl.req_ready <= 1'b0;
        ctl.busy      <= 1'b1;
      end
    end else if (bnd) begin
      state         <= RUN;
      ctl.cur_speed <= pend;
      ctl.req_ready <= 1'b1;
      ctl.busy      <= 1'b0;
    end
endmodule

// File: tb/tb_clk_div_speed_ctrl.sv
// tb_clk_div_speed_ctrl: directed bench with an edge-scheduled reference model and literal spot checks
module tb_clk_div_speed_ctrl;
  localparam int H0 = 4, H1 = 2, H2 = 3, H3 = 1, DWELL = 2;
  typedef struct packed {
    int e;
    int nt;
    int dw;
    logic clk;
    logic tick;
    logic pend;
    logic [1:0] spd;
    logic [1:0] pv;
  } mst_t;
  logic Clk50MHz = 1'b0;
  logic Rst = 1'b1;
  logic run = 1'b0;
  int vec = 0;
  int err = 0;
  mst_t ms;
  clk_div_speed_ctrl_if ctl();
  clk_div_speed_ctrl #(.CNT_W(4), .HALF_0(H0), .HALF_1(H1), .HALF_2(H2), .HALF_3(H3), .DWELL(DWELL)) dut (
    .Clk50MHz(Clk50MHz),
    .Rst(Rst),
    .ctl(ctl)
  );
  always #5 Clk50MHz = ~Clk50MHz;
  function automatic int hv(input logic [1:0] s);
    return s == 2'd0 ? H0 : s == 2'd1 ? H1 : s == 2'd2 ? H2 : H3;
  endfunction
  // Model schedules each toggle at an absolute edge number; a pending speed takes effect at that edge
  function automatic mst_t model(input mst_t s, input logic rst, input logic rv, input logic [1:0] sr, input logic ae);
    mst_t n = s;
    if (rst) begin
      n = '0;
      n.nt = hv(2'd0);
      return n;
    end
    n.e = s.e + 1;
    n.tick = 1'b0;
    if (n.e == s.nt) begin
      n.tick = !s.clk;
      n.clk = !s.clk;
      if (s.pend) begin
        n.spd = s.pv;
        n.pend = 1'b0;
      end
      n.nt = n.e + hv(n.spd);
    end
    if (!s.pend) begin
      if (rv) begin
        n.pend = 1'b1;
        n.pv = sr;
        n.dw = 0;
      end
`ifdef SPEED_AUTO_SEQ_EN
      else if (ae && s.tick) begin
        if (s.dw == DWELL - 1) begin
          n.pend = 1'b1;
          n.pv = s.spd + 2'd1;
          n.dw = 0;
        end else n.dw = s.dw + 1;
      end
`endif
    end
    if (!ae) n.dw = 0;
    return n;
  endfunction
  always @(posedge Clk50MHz) ms <= model(ms, Rst, ctl.req_valid, ctl.speed_req, ctl.auto_en);
  always @(negedge Clk50MHz)
    if (run) begin
      vec++;
      if ({ctl.ClkOut, ctl.tick, ctl.cur_speed, ctl.req_ready, ctl.busy} !== {ms.clk, ms.tick, ms.spd, !ms.pend, ms.pend}) begin
        err++;
        $display("FAIL model e=%0d: got clk=%b tick=%b spd=%0d rdy=%b busy=%b, expected clk=%b tick=%b spd=%0d rdy=%b busy=%b",
                 ms.e, ctl.ClkOut, ctl.tick, ctl.cur_speed, ctl.req_ready, ctl.busy, ms.clk, ms.tick, ms.spd, !ms.pend, ms.pend);
      end
    end
  task automatic step(input int n);
    repeat (n) @(posedge Clk50MHz);
    #1;
  endtask
  task automatic chk(input string nm, input int got, input int exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  int sp[6] = '{3, 2, 0, 1, 1, 3};
  int wt[6] = '{5, 9, 3, 7, 2, 6};
  initial begin
    ctl.req_valid = 1'b0;
    ctl.speed_req = 2'd0;
    ctl.auto_en = 1'b0;
    step(2);
    run = 1'b1;
    chk("rst_clk", ctl.ClkOut, 0);
    chk("rst_tick", ctl.tick, 0);
    chk("rst_spd", ctl.cur_speed, 0);
    chk("rst_rdy", ctl.req_ready, 1);
    chk("rst_busy", ctl.busy, 0);
    Rst = 1'b0;
    step(3);
    chk("e3_clk", ctl.ClkOut, 0);
    step(1);
    chk("e4_clk", ctl.ClkOut, 1);
    chk("e4_tick", ctl.tick, 1);
    step(1);
    chk("e5_tick", ctl.tick, 0);
    step(3);
    chk("e8_clk", ctl.ClkOut, 0);
    step(4);
    chk("e12_tick", ctl.tick, 1);
    step(8);
    chk("e20_tick", ctl.tick, 1);
    Rst = 1'b1;
    step(1);
    Rst = 1'b0;
    step(2);
    ctl.speed_req = 2'd1;
    ctl.req_valid = 1'b1;
    step(1);
    chk("acc_rdy", ctl.req_ready, 0);
    chk("acc_busy", ctl.busy, 1);
    chk("acc_spd", ctl.cur_speed, 0);
    ctl.speed_req = 2'd3;
    step(1);
    chk("apply_spd", ctl.cur_speed, 1);
    chk("apply_clk", ctl.ClkOut, 1);
    chk("apply_rdy", ctl.req_ready, 1);
    step(1);
    chk("reacc_busy", ctl.busy, 1);
    chk("reacc_spd", ctl.cur_speed, 1);
    ctl.req_valid = 1'b0;
    step(1);
    chk("e6_clk", ctl.ClkOut, 0);
    chk("e6_spd", ctl.cur_speed, 3);
    step(1);
    chk("e7_clk", ctl.ClkOut, 1);
    chk("e7_tick", ctl.tick, 1);
    step(1);
    chk("e8_fast_clk", ctl.ClkOut, 0);
    chk("e8_fast_tick", ctl.tick, 0);
    step(1);
    chk("e9_tick", ctl.tick, 1);
    ctl.speed_req = 2'd2;
    ctl.req_valid = 1'b1;
    step(1);
    chk("pend_busy", ctl.busy, 1);
    ctl.req_valid = 1'b0;
    Rst = 1'b1;
    step(1);
    chk("midrst_clk", ctl.ClkOut, 0);
    chk("midrst_spd", ctl.cur_speed, 0);
    chk("midrst_busy", ctl.busy, 0);
    chk("midrst_rdy", ctl.req_ready, 1);
    Rst = 1'b0;
    step(4);
    chk("lost_clk", ctl.ClkOut, 1);
    chk("lost_spd", ctl.cur_speed, 0);
    step(4);
    chk("lost_fall", ctl.ClkOut, 0);
    ctl.speed_req = 2'd0;
    ctl.req_valid = 1'b1;
    step(1);
    ctl.req_valid = 1'b0;
    step(3);
    chk("same_clk", ctl.ClkOut, 1);
    chk("same_tick", ctl.tick, 1);
    chk("same_spd", ctl.cur_speed, 0);
    chk("same_busy", ctl.busy, 0);
    for (int i = 0; i < 6; i++) begin
      ctl.speed_req = 2'(sp[i]);
      ctl.req_valid = 1'b1;
      step(1);
      ctl.req_valid = 1'b0;
      step(wt[i]);
    end
    step(12);
`ifdef SPEED_AUTO_SEQ_EN
    Rst = 1'b1;
    step(1);
    Rst = 1'b0;
    ctl.auto_en = 1'b1;
    step(15);
    chk("auto_e15_spd", ctl.cur_speed, 0);
    chk("auto_e15_busy", ctl.busy, 1);
    step(1);
    chk("auto_e16_spd", ctl.cur_speed, 1);
    step(6);
    ctl.speed_req = 2'd3;
    ctl.req_valid = 1'b1;
    step(1);
    chk("auto_man_busy", ctl.busy, 1);
    ctl.req_valid = 1'b0;
    step(1);
    chk("auto_man_spd", ctl.cur_speed, 3);
    step(60);
    ctl.auto_en = 1'b0;
    step(10);
`endif
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
